// File: rtl/value_digit_decoder.sv
// Serial double-dabble binary-to-BCD converter with leading-zero blanking mask
// and saturation/overflow flag for values beyond the displayable range.
module value_digit_decoder #(
  parameter int IN_WIDTH = 40,
  parameter int DIGITS   = 6
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_start,
  input  logic [IN_WIDTH-1:0]   i_value,
  output logic                  o_busy,
  output logic                  o_valid,
  output logic [4*DIGITS-1:0]   o_digits,
  output logic [DIGITS-1:0]     o_lz_mask,
  output logic                  o_overflow
);

  localparam int                   CW      = $clog2(IN_WIDTH + 1);
  localparam logic [IN_WIDTH-1:0]  MAX_VAL = IN_WIDTH'(10**DIGITS - 1);
  localparam logic [DIGITS-1:0]    LZ_RST  = {{(DIGITS-1){1'b1}}, 1'b0};

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_e;

  state_e                    state_q, state_d;
  logic [IN_WIDTH-1:0]       bin_q, bin_d;
  logic [DIGITS-1:0][3:0]    bcd_q, bcd_d, bcd_adj;
  logic [4*DIGITS-1:0]       adj_flat;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic                      ovf_rec_q, ovf_rec_d;
  logic                      valid_q, valid_d;
  logic [DIGITS-1:0][3:0]    digits_q, digits_d;
  logic [DIGITS-1:0]         lz_q, lz_d, lz_calc;
  logic                      ovf_q, ovf_d;
  logic                      allz;

  // One add-3 corrector per BCD digit, applied before every shift.
  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    value_digit_decoder_add3 u_add3 (
      .i_nib (bcd_q[g]),
      .o_nib (bcd_adj[g])
    );
  end

  assign adj_flat = bcd_adj;

  // Blank digits from the top while they stay zero; units digit always shown.
  always_comb begin
    allz    = 1'b1;
    lz_calc = '0;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      allz       = allz & (bcd_q[i] == 4'd0);
      lz_calc[i] = allz;
    end
  end

  always_comb begin
    state_d   = state_q;
    bin_d     = bin_q;
    bcd_d     = bcd_q;
    cnt_d     = cnt_q;
    ovf_rec_d = ovf_rec_q;
    valid_d   = 1'b0;
    digits_d  = digits_q;
    lz_d      = lz_q;
    ovf_d     = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          // Saturate up front so the accumulator can never carry out.
          if (i_value > MAX_VAL) begin
            bin_d     = MAX_VAL;
            ovf_rec_d = 1'b1;
          end else begin
            bin_d     = i_value;
            ovf_rec_d = 1'b0;
          end
          bcd_d   = '0;
          cnt_d   = '0;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        bcd_d = {adj_flat[4*DIGITS-2:0], bin_q[IN_WIDTH-1]};
        bin_d = {bin_q[IN_WIDTH-2:0], 1'b0};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(IN_WIDTH - 1)) state_d = S_DONE;
      end
      S_DONE: begin
        digits_d = bcd_q;
        lz_d     = lz_calc;
        ovf_d    = ovf_rec_q;
        valid_d  = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= S_IDLE;
      bin_q     <= '0;
      bcd_q     <= '0;
      cnt_q     <= '0;
      ovf_rec_q <= 1'b0;
      valid_q   <= 1'b0;
      digits_q  <= '0;
      lz_q      <= LZ_RST;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      bin_q     <= bin_d;
      bcd_q     <= bcd_d;
      cnt_q     <= cnt_d;
      ovf_rec_q <= ovf_rec_d;
      valid_q   <= valid_d;
      digits_q  <= digits_d;
      lz_q      <= lz_d;
      ovf_q     <= ovf_d;
    end
  end

  assign o_busy     = (state_q != S_IDLE);
  assign o_valid    = valid_q;
  assign o_digits   = digits_q;
  assign o_lz_mask  = lz_q;
  assign o_overflow = ovf_q;

endmodule

// Double-dabble digit corrector: nibbles of 5..9 get +3 so the next shift carries.
module value_digit_decoder_add3 (
  input  logic [3:0] i_nib,
  output logic [3:0] o_nib
);
  assign o_nib = (i_nib >= 4'd5) ? i_nib + 4'd3 : i_nib;
endmodule

// File: tb/tb_value_digit_decoder.sv
// Directed plus random checks of value_digit_decoder against a divide/modulo model.
module tb_value_digit_decoder;

  logic        i_clk, i_rst_n, i_start;
  logic [39:0] i_value;
  logic        o_busy, o_valid, o_overflow;
  logic [23:0] o_digits;
  logic [5:0]  o_lz_mask;

  int total = 0;
  int bad   = 0;

  value_digit_decoder #(.IN_WIDTH(40), .DIGITS(6)) dut (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_start    (i_start),
    .i_value    (i_value),
    .o_busy     (o_busy),
    .o_valid    (o_valid),
    .o_digits   (o_digits),
    .o_lz_mask  (o_lz_mask),
    .o_overflow (o_overflow)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  function automatic longint unsigned sat(input logic [39:0] v);
    return (v > 40'd999999) ? 64'd999999 : 64'(v);
  endfunction

  function automatic logic [23:0] m_digits(input logic [39:0] v);
    longint unsigned x;
    logic [23:0] r;
    x = sat(v);
    r = '0;
    for (int i = 0; i < 6; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic logic [5:0] m_mask(input logic [39:0] v);
    longint unsigned x;
    int n;
    logic [5:0] m;
    x = sat(v);
    n = 1;
    while (x >= 10) begin
      x = x / 10;
      n++;
    end
    for (int i = 0; i < 6; i++) m[i] = (i >= n);
    return m;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_busy"},   64'(o_busy),     64'd0);
    chk({tag, "_valid"},  64'(o_valid),    64'd0);
    chk({tag, "_digits"}, 64'(o_digits),   64'd0);
    chk({tag, "_lz"},     64'(o_lz_mask),  64'b111110);
    chk({tag, "_ovf"},    64'(o_overflow), 64'd0);
  endtask

  task automatic chk_result(input string tag, input logic [39:0] v);
    chk({tag, "_digits"}, 64'(o_digits),   64'(m_digits(v)));
    chk({tag, "_lz"},     64'(o_lz_mask),  64'(m_mask(v)));
    chk({tag, "_ovf"},    64'(o_overflow), 64'(v > 40'd999999));
  endtask

  // Starts a conversion and waits for o_valid; returns in the o_valid cycle.
  task automatic convert(input string tag, input logic [39:0] v);
    int lat, busy_cnt;
    bit got;
    i_value = v;
    i_start = 1'b1;
    step();
    i_start  = 1'b0;
    busy_cnt = o_busy ? 1 : 0;
    lat = 0;
    got = 0;
    while (lat < 100 && !got) begin
      step();
      lat++;
      if (o_valid) got = 1;
      else if (o_busy) busy_cnt++;
    end
    chk({tag, "_got_valid"}, 64'(got), 64'd1);
    chk({tag, "_latency"},   64'(lat), 64'd41);
    chk({tag, "_busy_cyc"},  64'(busy_cnt), 64'd41);
    chk({tag, "_busy_at_valid"}, 64'(o_busy), 64'd0);
    chk_result(tag, v);
  endtask

  initial begin
    int n, vcnt;
    bit got;
    logic [39:0] v;
    i_rst_n = 1'b0;
    i_start = 1'b0;
    i_value = '0;
    #12;
    chk_reset_vals("reset");
    step();
    i_rst_n = 1'b1;
    step();
    chk_reset_vals("post_release");

    convert("zero", 40'd0);
    convert("v123456", 40'd123456);
    step();
    chk("v123456_single_pulse", 64'(o_valid), 64'd0);
    convert("v1000000", 40'd1000000);
    convert("vmax40", 40'hFF_FFFF_FFFF);
    convert("v42", 40'd42);
    convert("v999999", 40'd999999);

    // Start ignored mid-run; input wiggles have no effect.
    i_value = 40'd500;
    i_start = 1'b1;
    step();
    i_start = 1'b0;
    repeat (9) step();
    i_value = 40'd777;
    i_start = 1'b1;
    step();
    i_start = 1'b0;
    i_value = 40'(64'({$urandom(), $urandom()}));
    n = 10;
    got = 0;
    while (n < 100 && !got) begin
      step();
      n++;
      if (o_valid) got = 1;
    end
    chk("midrun_latency", 64'(n), 64'd41);
    chk_result("midrun", 40'd500);
    vcnt = 0;
    repeat (60) begin
      step();
      if (o_valid) vcnt++;
    end
    chk("midrun_no_second_valid", 64'(vcnt), 64'd0);

    // Back-to-back: start accepted during the o_valid cycle.
    convert("b2b_first", 40'd5);
    i_value = 40'd99;
    i_start = 1'b1;
    step();
    i_start = 1'b0;
    n = 1;
    got = o_valid;
    while (n < 100 && !got) begin
      step();
      n++;
      if (o_valid) got = 1;
    end
    chk("b2b_spacing", 64'(n), 64'd42);
    chk_result("b2b_second", 40'd99);

    // Reset mid-conversion aborts it.
    i_value = 40'd654321;
    i_start = 1'b1;
    step();
    i_start = 1'b0;
    repeat (20) step();
    i_rst_n = 1'b0;
    #1;
    chk_reset_vals("midreset");
    repeat (3) step();
    chk_reset_vals("midreset_held");
    i_rst_n = 1'b1;
    vcnt = 0;
    repeat (50) begin
      step();
      if (o_valid || o_busy) vcnt++;
    end
    chk("midreset_no_activity", 64'(vcnt), 64'd0);
    convert("after_reset_v10", 40'd10);

    for (int k = 0; k < 30; k++) begin
      case ($urandom_range(0, 3))
        0:       v = 40'($urandom_range(0, 999999));
        1:       v = 40'(64'({$urandom(), $urandom()}));
        2:       v = 40'($urandom_range(0, 99));
        default: v = 40'd999999 + 40'($urandom_range(0, 1));
      endcase
      convert("rand", v);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/value_digit_decoder.md
Name: value_digit_decoder

Overview:
- Reads the 40-bit binary value produced by the switch/push-button setup logic and decomposes it into six BCD digits for the seven-segment display path.
- Uses a serial shift-add-3 (double-dabble) engine with a start/busy/valid handshake.
- Also produces a leading-zero blanking mask and an overflow flag for values above 999999.

Parameters:
- IN_WIDTH, 40, width of binary input value.
- DIGITS, 6, number of BCD output digits. Internal localparam MAX_VAL = 10^DIGITS - 1 (999999 at default).

Ports:
- i_clk  input  1  system clock, rising edge.
- i_rst_n  input  1  asynchronous active-low reset.
- i_start  input  1  request conversion of i_value; sampled on i_clk rising edge.
- i_value  input  IN_WIDTH  binary value to convert; sampled only on the accepting edge.
- o_busy  output  1  conversion in progress; i_start ignored while high.
- o_valid  output  1  one-cycle pulse: o_digits/o_lz_mask/o_overflow just updated.
- o_digits  output  4*DIGITS  BCD digits; [3:0] = units, [4*DIGITS-1:4*DIGITS-4] = most significant.
- o_lz_mask  output  DIGITS  bit i = 1 when digit i is a leading zero (blank it); bit 0 always 0.
- o_overflow  output  1  last converted value exceeded MAX_VAL (digits saturated).

Behaviour:
- Reset (async, i_rst_n low): state IDLE, o_busy=0, o_valid=0, o_digits=0, o_overflow=0, o_lz_mask = all ones except bit 0. Internal shift/BCD registers and counter cleared. Release is synchronous to i_clk.
- Reset mid-conversion aborts it: no o_valid, outputs return to reset values.
- FSM states: IDLE, SHIFT, DONE.
- IDLE: on edge E with i_start=1, the block:
  - captures i_value; if i_value > MAX_VAL, loads MAX_VAL instead and records overflow=1, else overflow=0;
  - clears BCD accumulator and bit counter; o_busy=1; goes to SHIFT.
- SHIFT: each edge E+1 .. E+IN_WIDTH performs one iteration:
  - add 3 to every BCD nibble >= 5;
  - shift {BCD, binary} left by 1, MSB of binary entering BCD bit 0;
  - counter increments; after the IN_WIDTH-th shift (edge E+IN_WIDTH), goes to DONE.
- DONE: at edge E+IN_WIDTH+1:
  - o_digits <= accumulator, o_overflow <= recorded flag, o_lz_mask <= computed mask;
  - o_valid=1 for exactly this one cycle, o_busy=0; returns to IDLE.
- Latency: IN_WIDTH+1 cycles from accepting edge to o_valid (41 at default). o_busy high for cycles E..E+IN_WIDTH inclusive.
- i_start while o_busy=1 is ignored; it is not queued. i_value changes during conversion have no effect.
- i_start high during the o_valid cycle (state IDLE) is accepted; back-to-back throughput is one result per IN_WIDTH+2 cycles.
- o_digits, o_lz_mask, o_overflow hold their values between o_valid pulses.
- Leading-zero mask: scanning from the MS digit downward, bit i = 1 while digits DIGITS-1..i are all zero. Bit 0 is forced 0, so value 0 displays a single "0".
- Arithmetic: each BCD nibble never exceeds 9 after an iteration. Accumulator width is 4*DIGITS; saturation guarantees no carry out of the MS digit.

Test Plan:
- Convert 0 -> after 41 cycles o_valid=1, o_digits=0x000000, o_lz_mask=6'b111110, o_overflow=0.
- Convert 123456 -> o_digits=0x123456, o_lz_mask=6'b000000, o_overflow=0. Check o_busy high exactly 41 cycles and o_valid a single pulse at E+41.
- Convert 1000000, then 2^40-1 -> each gives o_digits=0x999999, o_overflow=1. Follow with 42 -> o_digits=0x000042, o_lz_mask=6'b111100, o_overflow=0.
- Start with 500; pulse i_start with 777 at E+10 and change i_value mid-run -> result 0x000500 only; no second o_valid.
- Assert i_start (value 99) in the o_valid cycle of a 5 conversion -> 0x000005 valid, then 0x000099 valid exactly 42 cycles later.
- Drop i_rst_n at E+20 of a 654321 conversion -> outputs immediately at reset values; no o_valid. After release, converting 10 -> 0x000010, o_lz_mask=6'b111100.
